// File: rtl/wb_mac_array_if.sv
// Wishbone classic slave bus bundle for wb_mac_array.
// master: drives stb/cyc/we/sel/dat_i/adr; slave: returns ack/dat_o.
interface wb_mac_array_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i,
    output wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i,
    input  wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_mac_array.sv
// Wishbone-mapped array of LANES signed MAC lanes, 3-stage pipeline.
// Ports: wb_clk_i/wb_rst_i, wbs (slave bus), irq_o, io_out/io_oeb.
module wb_mac_array #(
  parameter int LANES = 4,
  parameter int DW    = 16,
  parameter int ACCW  = 40,
  parameter int IO_W  = 38
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  wb_mac_array_if.slave   wbs,
  output logic            irq_o,
  output logic [IO_W-1:0] io_out,
  output logic [IO_W-1:0] io_oeb
);
  localparam logic [15:0] HMASK = 16'((32'd1 << DW) - 32'd1);
  localparam logic signed [ACCW-1:0] MAXV = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = {1'b1, {(ACCW-1){1'b0}}};

  logic        ack_q;
  logic [31:0] dat_q;
  logic [31:0] rdata;
  logic [3:0]  ctrl_q, ctrl_n;
  logic        done_q, ovf_q, err_q, irq_q;
  logic        done_n, ovf_n, err_n;
  logic [31:0] oper_q [LANES];

  logic        v0, v1, v2;
  logic [1:0]  mode0, mode1;
  logic        sat0, sat1, sat2;
  logic signed [DW-1:0]   a0 [LANES];
  logic signed [DW-1:0]   b0 [LANES];
  logic signed [2*DW-1:0] prod1 [LANES];
  logic signed [ACCW:0]   sum_c [LANES];
  logic signed [ACCW:0]   sum2 [LANES];
  logic [LANES-1:0]       ovf_c, ovf2;
  logic signed [ACCW-1:0] acc_q [LANES];
  logic signed [ACCW-1:0] res_c [LANES];

  logic       req, wr, busy;
  logic [5:0] idx;
  logic [2:0] lsel;
  logic       lane_ok;
  logic       is_ctrl, is_cmd, is_stat, is_oper, is_acc;
  logic       cmd_wr, go_req, clr_req;
  logic       err_set, do_clr, do_go;
  logic [2:0] w1c;
  logic       unused_adr;

  assign req  = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q;
  assign wr   = req & wbs.wbs_we_i;
  assign idx  = wbs.wbs_adr_i[7:2];
  assign lsel = idx[3:1];
  assign lane_ok = {29'd0, lsel} < 32'(LANES);
  assign unused_adr = ^{wbs.wbs_adr_i[31:8], wbs.wbs_adr_i[1:0]};

  assign is_ctrl = idx == 6'd0;
  assign is_cmd  = idx == 6'd1;
  assign is_stat = idx == 6'd2;
  assign is_oper = idx[5:4] == 2'b01 && !idx[0] && lane_ok;
  assign is_acc  = idx[5:4] == 2'b10 && lane_ok;

  assign busy    = v0 | v1 | v2;
  assign cmd_wr  = wr & is_cmd & wbs.wbs_sel_i[0];
  assign go_req  = cmd_wr & wbs.wbs_dat_i[0];
  assign clr_req = cmd_wr & wbs.wbs_dat_i[1];
  assign err_set = (go_req | clr_req) & busy;
  assign do_clr  = clr_req & ~busy;
  assign do_go   = go_req & ~clr_req & ~busy;

  assign w1c = (wr & is_stat & wbs.wbs_sel_i[0]) ?
               wbs.wbs_dat_i[3:1] : 3'd0;
  assign ctrl_n = (wr & is_ctrl & wbs.wbs_sel_i[0]) ?
                  wbs.wbs_dat_i[3:0] : ctrl_q;

  // Pipeline sets beat same-cycle software clears.
  assign done_n = (done_q & ~w1c[0] & ~do_clr) | v2;
  assign ovf_n  = (ovf_q & ~w1c[1]) | (v2 & |ovf2);
  assign err_n  = (err_q & ~w1c[2]) | err_set;

  always_comb begin
    logic signed [63:0] ax;
    rdata = '0;
    ax    = '0;
    unique case (1'b1)
      is_ctrl: rdata = {28'd0, ctrl_q};
      is_stat: rdata = {28'd0, err_q, ovf_q, done_q, busy};
      is_oper: begin
        for (int l = 0; l < LANES; l++)
          if (lsel == 3'(l))
            rdata = oper_q[l] & {HMASK, HMASK};
      end
      is_acc: begin
        for (int l = 0; l < LANES; l++)
          if (lsel == 3'(l)) begin
            ax = 64'(acc_q[l]);
            if (idx[0])
              rdata = (ACCW > 32) ? ax[63:32] : 32'd0;
            else
              rdata = ax[31:0];
          end
      end
      default: rdata = '0;
    endcase
  end

  // Stage 2 add/sub in ACCW+1 bits; stage 3 clamp or wrap.
  always_comb begin
    logic signed [ACCW:0] pe, ae;
    pe = '0;
    ae = '0;
    for (int l = 0; l < LANES; l++) begin
      pe = (ACCW+1)'(prod1[l]);
      ae = (ACCW+1)'(acc_q[l]);
      case (mode1)
        2'd1:    sum_c[l] = ae + pe;
        2'd2:    sum_c[l] = ae - pe;
        default: sum_c[l] = pe;
      endcase
      ovf_c[l] = sum_c[l][ACCW] ^ sum_c[l][ACCW-1];
      if (ovf2[l] && sat2)
        res_c[l] = sum2[l][ACCW] ? MINV : MAXV;
      else
        res_c[l] = sum2[l][ACCW-1:0];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      ctrl_q <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
      irq_q  <= 1'b0;
      v0     <= 1'b0;
      v1     <= 1'b0;
      v2     <= 1'b0;
      mode0  <= '0;
      mode1  <= '0;
      sat0   <= 1'b0;
      sat1   <= 1'b0;
      sat2   <= 1'b0;
      ovf2   <= '0;
      for (int l = 0; l < LANES; l++) begin
        oper_q[l] <= '0;
        a0[l]     <= '0;
        b0[l]     <= '0;
        prod1[l]  <= '0;
        sum2[l]   <= '0;
        acc_q[l]  <= '0;
      end
    end else begin
      ack_q  <= req;
      dat_q  <= (req & ~wbs.wbs_we_i) ? rdata : '0;
      ctrl_q <= ctrl_n;
      done_q <= done_n;
      ovf_q  <= ovf_n;
      err_q  <= err_n;
      irq_q  <= done_n & ctrl_n[3];
      v0 <= do_go;
      v1 <= v0;
      v2 <= v1;
      if (do_go) begin
        mode0 <= ctrl_q[1:0];
        sat0  <= ctrl_q[2];
      end
      mode1 <= mode0;
      sat1  <= sat0;
      sat2  <= sat1;
      ovf2  <= ovf_c;
      for (int l = 0; l < LANES; l++) begin
        if (wr && is_oper && lsel == 3'(l))
          for (int b = 0; b < 4; b++)
            if (wbs.wbs_sel_i[b])
              oper_q[l][8*b +: 8] <= wbs.wbs_dat_i[8*b +: 8];
        if (do_go) begin
          a0[l] <= oper_q[l][DW-1:0];
          b0[l] <= oper_q[l][16 +: DW];
        end
        prod1[l] <= (2*DW)'(a0[l]) * (2*DW)'(b0[l]);
        sum2[l]  <= sum_c[l];
        if (do_clr)
          acc_q[l] <= '0;
        else if (v2)
          acc_q[l] <= res_c[l];
      end
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign irq_o  = irq_q;
  assign io_out = IO_W'({ovf_q, done_q, busy});
  assign io_oeb = '0;
endmodule

// File: tb/tb_wb_mac_array.sv
// Scoreboard bench for wb_mac_array (LANES=4, DW=16, ACCW=40).
// Reads queue expectations; a monitor pops on every ack.
module tb_wb_mac_array;
  localparam int LANES = 4;
  localparam int DW    = 16;
  localparam int ACCW  = 40;
  localparam int IO_W  = 38;
  localparam longint MAXV = 64'sd549755813887;
  localparam longint MINV = -64'sd549755813888;
  localparam longint SPAN = 64'sd1099511627776;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  logic [IO_W-1:0] io_out, io_oeb;

  wb_mac_array_if bus();

  wb_mac_array #(
    .LANES(LANES), .DW(DW), .ACCW(ACCW), .IO_W(IO_W)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wbs(bus.slave),
    .irq_o(irq),
    .io_out(io_out),
    .io_oeb(io_oeb)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [31:0] adr;
    logic [31:0] exp;
  } txn_t;

  txn_t sb[$];
  txn_t mon_t;
  int n_chk = 0;
  int n_fail = 0;

  logic [3:0]  m_ctrl;
  logic [31:0] m_oper [LANES];
  longint      m_acc [LANES];
  bit          m_done, m_ovf, m_err;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.wbs_ack_o) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_ack: got ack want none");
      end else begin
        mon_t = sb.pop_front();
        if (mon_t.is_rd)
          check($sformatf("rd_%02h", mon_t.adr[7:0]),
                bus.wbs_dat_o, mon_t.exp);
      end
    end
  end

  task automatic wb_xfer(input bit is_rd, input logic [7:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         input logic [31:0] exp);
    bit got = 0;
    @(negedge clk);
    sb.push_back('{is_rd: is_rd, adr: {24'd0, adr}, exp: exp});
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = !is_rd;
    bus.wbs_adr_i = {24'd0, adr};
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk);
      #1;
      got = bus.wbs_ack_o;
    end
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_timeout: got no ack want ack adr=%h", adr);
      void'(sb.pop_back());
    end
  endtask

  task automatic wb_wr(input logic [7:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    wb_xfer(1'b0, adr, dat, sel, 32'd0);
  endtask

  task automatic wb_rd(input logic [7:0] adr, input logic [31:0] exp);
    wb_xfer(1'b1, adr, 32'd0, 4'hF, exp);
  endtask

  task automatic model_reset();
    m_ctrl = '0;
    m_done = 0;
    m_ovf  = 0;
    m_err  = 0;
    for (int l = 0; l < LANES; l++) begin
      m_oper[l] = '0;
      m_acc[l]  = 0;
    end
  endtask

  task automatic model_go();
    longint a, b, p, t;
    for (int l = 0; l < LANES; l++) begin
      a = longint'(signed'(m_oper[l][15:0]));
      b = longint'(signed'(m_oper[l][31:16]));
      p = a * b;
      if (m_ctrl[1:0] == 2'd1)
        t = m_acc[l] + p;
      else if (m_ctrl[1:0] == 2'd2)
        t = m_acc[l] - p;
      else
        t = p;
      if (t > MAXV || t < MINV) begin
        m_ovf = 1;
        if (m_ctrl[2]) begin
          t = (t > MAXV) ? MAXV : MINV;
        end else begin
          while (t > MAXV) t -= SPAN;
          while (t < MINV) t += SPAN;
        end
      end
      m_acc[l] = t;
    end
    m_done = 1;
  endtask

  task automatic ctrl_wr(input logic [3:0] d, input logic [3:0] sel);
    wb_wr(8'h00, {28'd0, d}, sel);
    if (sel[0]) m_ctrl = d;
  endtask

  task automatic stat_wr(input logic [3:0] d);
    wb_wr(8'h08, {28'd0, d}, 4'h1);
    if (d[3]) m_err = 0;
    if (d[2]) m_ovf = 0;
    if (d[1]) m_done = 0;
  endtask

  task automatic oper_wr(input int l, input logic [31:0] d,
                         input logic [3:0] sel);
    wb_wr(8'(64 + 8 * l), d, sel);
    for (int b = 0; b < 4; b++)
      if (sel[b]) m_oper[l][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic cmd_clr();
    wb_wr(8'h04, 32'h2, 4'h1);
    for (int l = 0; l < LANES; l++) m_acc[l] = 0;
    m_done = 0;
  endtask

  task automatic check_lane(input int l);
    logic [63:0] v;
    v = m_acc[l];
    wb_rd(8'(128 + 8 * l), v[31:0]);
    wb_rd(8'(132 + 8 * l), v[63:32]);
  endtask

  task automatic check_all();
    for (int l = 0; l < LANES; l++) check_lane(l);
    wb_rd(8'h08, {28'd0, m_err, m_ovf, m_done, 1'b0});
  endtask

  task automatic go_checked();
    wb_wr(8'h04, 32'h1, 4'h1);
    check("busy_t1", {31'd0, io_out[0]}, 32'd1);
    @(posedge clk);
    #1;
    check("busy_t2", {31'd0, io_out[0]}, 32'd1);
    @(posedge clk);
    #1;
    check("busy_t3", {31'd0, io_out[0]}, 32'd1);
    @(posedge clk);
    #1;
    model_go();
    check("busy_t4", {31'd0, io_out[0]}, 32'd0);
    check("done_t4", {31'd0, io_out[1]}, 32'd1);
    check("irq_t4", {31'd0, irq}, {31'd0, m_done & m_ctrl[3]});
  endtask

  task automatic go_fast();
    wb_wr(8'h04, 32'h1, 4'h1);
    repeat (3) @(posedge clk);
    model_go();
  endtask

  initial begin
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = '0;
    bus.wbs_dat_i = '0;
    bus.wbs_adr_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    check("rst_dat", bus.wbs_dat_o, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_io_lo", io_out[31:0], 32'd0);
    check("rst_io_hi", {26'd0, io_out[37:32]}, 32'd0);
    check("oeb_lo", io_oeb[31:0], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wb_rd(8'h00, 32'd0);
    check_all();

    // single MUL: 3 * -5
    oper_wr(0, 32'hFFFB0003, 4'hF);
    go_checked();
    wb_rd(8'h80, 32'hFFFFFFF1);
    wb_rd(8'h84, 32'hFFFFFFFF);
    check_all();

    // MAC twice on lane 1
    cmd_clr();
    ctrl_wr(4'b0001, 4'h1);
    oper_wr(1, 32'h7FFF7FFF, 4'hF);
    go_checked();
    go_checked();
    wb_rd(8'h88, 32'h7FFE0002);
    wb_rd(8'h8C, 32'd0);
    check_all();

    // GO while busy: one op, ERR set
    wb_wr(8'h04, 32'h1, 4'h1);
    wb_wr(8'h04, 32'h1, 4'h1);
    repeat (4) @(posedge clk);
    model_go();
    m_err = 1;
    check_all();

    // CLR while busy is ignored, sets ERR
    stat_wr(4'b1110);
    wb_wr(8'h04, 32'h1, 4'h1);
    wb_wr(8'h04, 32'h2, 4'h1);
    repeat (4) @(posedge clk);
    model_go();
    m_err = 1;
    check_all();

    // DONE w1c landing on the completion edge: set wins
    stat_wr(4'b1110);
    wb_wr(8'h04, 32'h1, 4'h1);
    repeat (2) @(posedge clk);
    wb_wr(8'h08, 32'h2, 4'h1);
    model_go();
    check_all();

    // CLR+GO together with nonzero accumulators
    stat_wr(4'b1110);
    go_fast();
    wb_wr(8'h04, 32'h3, 4'h1);
    for (int l = 0; l < LANES; l++) m_acc[l] = 0;
    m_done = 0;
    repeat (4) @(posedge clk);
    check_all();
    wb_rd(8'hFC, 32'd0);
    wb_wr(8'hFC, 32'hFFFFFFFF, 4'hF);
    wb_rd(8'h44, 32'd0);
    wb_wr(8'h60, 32'h12345678, 4'hF);
    wb_rd(8'h60, 32'd0);
    wb_rd(8'hA0, 32'd0);
    wb_wr(8'h04, 32'h1, 4'h0);
    repeat (4) @(posedge clk);
    check_all();

    // IRQ follows DONE & IRQ_EN
    ctrl_wr(4'b1000, 4'h1);
    go_checked();
    stat_wr(4'b0010);
    check("irq_clr", {31'd0, irq}, 32'd0);

    // randomized operands, modes and byte selects
    for (int it = 0; it < 40; it++) begin
      int l;
      l = $urandom_range(0, LANES - 1);
      oper_wr(l, $urandom(), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1)
        ctrl_wr(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      go_checked();
      wb_rd(8'(64 + 8 * l), m_oper[l]);
      check_lane(l);
      if (it % 8 == 7) stat_wr(4'($urandom_range(0, 15)));
    end
    check_all();

    // saturation on lane 2
    cmd_clr();
    stat_wr(4'b1110);
    ctrl_wr(4'b0101, 4'h1);
    oper_wr(2, 32'h80008000, 4'hF);
    for (int i = 0; i < 512; i++) go_fast();
    wb_rd(8'h90, 32'hFFFFFFFF);
    wb_rd(8'h94, 32'h0000007F);
    check_all();

    // same run wrapping
    cmd_clr();
    stat_wr(4'b1110);
    ctrl_wr(4'b0001, 4'h1);
    for (int i = 0; i < 512; i++) go_fast();
    wb_rd(8'h90, 32'h00000000);
    wb_rd(8'h94, 32'hFFFFFF80);
    check_all();

    // reset two cycles into an operation
    ctrl_wr(4'b1001, 4'h1);
    go_fast();
    check("irq_pre_rst", {31'd0, irq}, 32'd1);
    wb_wr(8'h04, 32'h1, 4'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check("irq_post_rst", {31'd0, irq}, 32'd0);
    check("io_post_rst", io_out[31:0], 32'd0);
    check_all();
    wb_rd(8'h00, 32'd0);
    wb_rd(8'h40, 32'd0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
